frame_drawer: RTL and testbench

- Reader side of the game-state memory. On each frame tick it snapshots the memory block's ball and platform outputs and streams them as pixel writes to the VGA adapter (x, y, colour, plot).
- Each frame it erases the previous ball, draws the current ball, then draws the four platforms.
- Sits between the game-state memory and the VGA adapter. The frame-tick generator drives start.

---
 rtl/frame_drawer.sv | 213 +++++++++++++++++++++
 tb/tb_frame_drawer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/frame_drawer.sv
// frame_drawer: on each accepted start, snapshots the ball/platform state and
// streams one pixel per cycle to the VGA adapter. The sequence is: erase the
// previous ball, draw the current ball, draw the four platforms, then pulse done.
// Pixels that fall off the 160x120 screen still take their cycle, but they are
// not plotted.
module frame_drawer #(
    parameter int unsigned BALL_X    = 76,
    parameter int unsigned BALL_SIZE = 4,
    parameter int unsigned PLAT_Y    = 100,
    parameter int unsigned PLAT_W    = 16,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  prev_ball,
    input  logic [7:0]  curr_ball,
    input  logic [2:0]  color_ball,
    input  logic [11:0] color_plats,
    input  logic [31:0] position_plats,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERASE = 3'd1,
        S_BALL  = 3'd2,
        S_PLAT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  dx_q, dx_d;
    logic [7:0]  dy_q, dy_d;
    logic [1:0]  pi_q, pi_d;

    // Snapshot of the game state, taken when a frame is accepted.
    logic [7:0]  prev_q, prev_d;
    logic [7:0]  curr_q, curr_d;
    logic [2:0]  cball_q, cball_d;
    logic [11:0] cplats_q, cplats_d;
    logic [31:0] pos_q, pos_d;

    // Registered pixel-port outputs.
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Working values for the pixel of the current cycle.
    logic [8:0]  col_s;
    logic [8:0]  row_s;
    logic [2:0]  pix_colour_s;
    logic        pix_en_s;
    logic [7:0]  plat_pos_s;
    logic [2:0]  plat_colour_s;

    // Selects the active platform's left column and colour.
    always_comb begin
        plat_pos_s    = 8'd0;
        plat_colour_s = 3'd0;
        case (pi_q)
            2'd0: begin plat_pos_s = pos_q[7:0];   plat_colour_s = cplats_q[2:0];  end
            2'd1: begin plat_pos_s = pos_q[15:8];  plat_colour_s = cplats_q[5:3];  end
            2'd2: begin plat_pos_s = pos_q[23:16]; plat_colour_s = cplats_q[8:6];  end
            2'd3: begin plat_pos_s = pos_q[31:24]; plat_colour_s = cplats_q[11:9]; end
            default: begin plat_pos_s = 8'd0; plat_colour_s = 3'd0; end
        endcase
    end

    // Next-state, counter and snapshot logic, plus the pixel for this cycle.
    always_comb begin
        state_d      = state_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        pi_d         = pi_q;
        prev_d       = prev_q;
        curr_d       = curr_q;
        cball_d      = cball_q;
        cplats_d     = cplats_q;
        pos_d        = pos_q;
        col_s        = 9'd0;
        row_s        = 9'd0;
        pix_colour_s = 3'd0;
        pix_en_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    prev_d   = prev_ball;
                    curr_d   = curr_ball;
                    cball_d  = color_ball;
                    cplats_d = color_plats;
                    pos_d    = position_plats;
                    dx_d     = 8'd0;
                    dy_d     = 8'd0;
                    pi_d     = 2'd0;
                    state_d  = S_ERASE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ERASE, S_BALL: begin
                col_s    = 9'(BALL_X) + {1'b0, dx_q};
                pix_en_s = 1'b1;
                if (state_q == S_ERASE) begin
                    row_s        = {1'b0, prev_q} + {1'b0, dy_q};
                    pix_colour_s = BG_COLOUR;
                end else begin
                    row_s        = {1'b0, curr_q} + {1'b0, dy_q};
                    pix_colour_s = cball_q;
                end
                // Row-major walk: dx inner, dy outer.
                if (dx_q == 8'(BALL_SIZE - 1)) begin
                    dx_d = 8'd0;
                    if (dy_q == 8'(BALL_SIZE - 1)) begin
                        dy_d    = 8'd0;
                        state_d = (state_q == S_ERASE) ? S_BALL : S_PLAT;
                    end else begin
                        dy_d = dy_q + 8'd1;
                    end
                end else begin
                    dx_d = dx_q + 8'd1;
                end
            end
            S_PLAT: begin
                col_s        = {1'b0, plat_pos_s} + {1'b0, dx_q};
                row_s        = 9'(PLAT_Y);
                pix_colour_s = plat_colour_s;
                pix_en_s     = 1'b1;
                if (dx_q == 8'(PLAT_W - 1)) begin
                    dx_d = 8'd0;
                    if (pi_q == 2'd3) begin
                        pi_d    = 2'd0;
                        state_d = S_DONE;
                    end else begin
                        pi_d = pi_q + 2'd1;
                    end
                end else begin
                    dx_d = dx_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output stage: off-screen pixels keep their slot but are not plotted.
    always_comb begin
        x_d      = col_s[7:0];
        y_d      = row_s[6:0];
        colour_d = pix_colour_s;
        plot_d   = pix_en_s && (col_s < 9'd160) && (row_s < 9'd120);
        busy_d   = (state_q != S_IDLE);
        done_d   = (state_q == S_DONE);
    end

    // State, counter, snapshot and output registers; async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            dx_q     <= 8'd0;
            dy_q     <= 8'd0;
            pi_q     <= 2'd0;
            prev_q   <= 8'd0;
            curr_q   <= 8'd0;
            cball_q  <= 3'd0;
            cplats_q <= 12'd0;
            pos_q    <= 32'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            pi_q     <= pi_d;
            prev_q   <= prev_d;
            curr_q   <= curr_d;
            cball_q  <= cball_d;
            cplats_q <= cplats_d;
            pos_q    <= pos_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_frame_drawer.sv
// Testbench for frame_drawer: a scoreboard of expected per-cycle outputs is
// filled from a reference model when a frame is started, then popped and
// compared cycle by cycle.
module tb_frame_drawer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  prev_ball;
    logic [7:0]  curr_ball;
    logic [2:0]  color_ball;
    logic [11:0] color_plats;
    logic [31:0] position_plats;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    // Expected entry layout: {chk_pix, busy, done, plot, colour, y, x}.
    logic [21:0] exp_q[$];

    // Alternate stimulus, applied part-way through the snapshot test.
    logic [7:0]  alt_prev  = 8'd10;
    logic [7:0]  alt_curr  = 8'd20;
    logic [2:0]  alt_cball = 3'b010;
    logic [11:0] alt_cp    = 12'hABC;
    logic [31:0] alt_pos   = 32'h01020304;

    frame_drawer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .prev_ball      (prev_ball),
        .curr_ball      (curr_ball),
        .color_ball     (color_ball),
        .color_plats    (color_plats),
        .position_plats (position_plats),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .busy           (busy),
        .done           (done)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] pix(input int col, input int row, input logic [2:0] c);
        logic p;
        logic [7:0] xx;
        logic [6:0] yy;
        p  = (col < 160) && (row < 120);
        xx = col[7:0];
        yy = row[6:0];
        return {1'b1, 1'b1, 1'b0, p, c, yy, xx};
    endfunction

    // Reference model: push one frame's expected outputs from the current inputs.
    task automatic push_frame();
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++)
                exp_q.push_back(pix(76 + dx, int'(prev_ball) + dy, 3'b000));
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++)
                exp_q.push_back(pix(76 + dx, int'(curr_ball) + dy, color_ball));
        for (int i = 0; i < 4; i++)
            for (int dx = 0; dx < 16; dx++)
                exp_q.push_back(pix(int'(position_plats[8*i +: 8]) + dx, 100,
                                    color_plats[3*i +: 3]));
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 18'd0});  // done cycle
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 18'd0});  // back to idle
    endtask

    task automatic apply_alt();
        prev_ball      = alt_prev;
        curr_ball      = alt_curr;
        color_ball     = alt_cball;
        color_plats    = alt_cp;
        position_plats = alt_pos;
    endtask

    // Run one frame; mut_at>0 changes inputs at that cycle and pulses start
    // 10 cycles later; rst_at>0 asserts reset mid-frame at that cycle.
    task automatic run_frame(input int mut_at, input int rst_at, input string tag);
        logic [21:0] e;
        logic [21:0] got;
        logic [21:0] mask;
        push_frame();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 98; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                #2 reset = 1'b0;
                #1;
                check_eq($sformatf("%s_rst_now", tag), {11'd0, x, y, colour, plot, busy, done}, 32'd0);
                repeat (10) begin
                    @(negedge clk);
                    check_eq($sformatf("%s_rst_hold", tag), {29'd0, plot, busy, done}, 32'd0);
                end
                reset = 1'b1;
                exp_q.delete();
                return;
            end
            e    = exp_q.pop_front();
            got  = {e[21], busy, done, plot, colour, y, x};
            mask = e[21] ? 22'h3FFFFF : 22'h3C0000;
            check_eq($sformatf("%s_c%0d", tag, k), {10'd0, got & mask}, {10'd0, e & mask});
            if (mut_at > 0) begin
                if (k == mut_at)      apply_alt();
                if (k == mut_at + 10) start = 1'b1;
                if (k == mut_at + 11) start = 1'b0;
            end
        end
    endtask

    initial begin
        int hi;
        reset          = 1'b0;
        start          = 1'b0;
        prev_ball      = 8'd40;
        curr_ball      = 8'd44;
        color_ball     = 3'b100;
        color_plats    = 12'b001110111101;
        position_plats = 32'h5F73879B;

        // Reset values are visible without any clock edge.
        #2;
        check_eq("reset_outs", {11'd0, x, y, colour, plot, busy, done}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // No start: nothing is plotted and the block stays idle.
        hi = 0;
        repeat (200) begin
            @(negedge clk);
            if (plot || busy || done) hi++;
        end
        check_eq("idle_quiet", hi, 0);

        // Nominal frame.
        run_frame(-1, -1, "nom");

        // Clipping: ball crosses the bottom edge, platform 0 crosses the right edge.
        prev_ball = 8'd116;
        curr_ball = 8'd118;
        run_frame(-1, -1, "clip");

        // Snapshot: inputs change and start is pulsed while busy.
        prev_ball = 8'd40;
        curr_ball = 8'd44;
        run_frame(10, -1, "snap");
        run_frame(-1, -1, "newvals");

        // Reset mid-frame, then a full frame after release.
        run_frame(-1, 40, "rstmid");
        repeat (2) @(negedge clk);
        run_frame(-1, -1, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
